decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
//   RV32I instruction-decode stage; sits between fetch and execute.
//   Drives the register file read selects and bypasses the same-cycle writeback
//   value. Generates immediates and control bits. Detects load-use hazards.
//   Holds all results in the ID/EX pipeline register with valid/ready handshakes.
// PARAMETERS
//   XLEN        32   datapath width
// PORTS
//   clock          in   1     rising-edge clock
//   reset          in   1     synchronous, active-low reset
//   if_valid       in   1     fetch presents an instruction
//   if_instr       in   32    instruction word
//   if_pc          in   32    instruction PC
//   id_ready       out  1     decode accepts if_instr this cycle
//   read_sel1      out  5     to register file, = if_instr[19:15]
//   read_sel2      out  5     to register file, = if_instr[24:20]
//   read_data1     in   32    from register file (combinational read)
//   read_data2     in   32    from register file (combinational read)
//   wb_wEn         in   1     writeback write enable (same net as the regfile wEn)
//   wb_write_sel   in   5     writeback destination
//   wb_write_data  in   32    writeback data
//   ex_ready       in   1     execute accepts the ID/EX contents
//   flush          in   1     kill the in-flight instruction (taken branch/jump)
//   ex_valid       out  1     ID/EX holds a valid instruction
//   ex_pc          out  32    latched PC
//   ex_rs1_val     out  32    operand 1 after bypass
//   ex_rs2_val     out  32    operand 2 after bypass
//   ex_imm         out  32    sign-extended immediate
//   ex_rd          out  5     destination; forced to 0 when ex_reg_write = 0
//   ex_opcode      out  7     instr[6:0]
//   ex_funct3      out  3     instr[14:12]
//   ex_funct7b5    out  1     instr[30]
//   ex_reg_write   out  1     instruction writes rd
//   ex_mem_read    out  1     opcode is LOAD
//   ex_illegal     out  1     opcode is not RV32I
// BEHAVIOUR
//   Reset (reset = 0 at a clock edge): all ex_* outputs go to 0. id_ready is 0 while reset = 0.
//   advance = !ex_valid | ex_ready.
//   Load-use hazard, computed combinationally:
//     hazard = ex_valid & ex_mem_read & (ex_rd != 0) &
//              ((rs1_used & rs1 == ex_rd) | (rs2_used & rs2 == ex_rd)).
//   rs1 is unused only for LUI, AUIPC and JAL.
//   rs2 is used only for OP, STORE and BRANCH.
//   id_ready = reset & advance & !hazard, or id_ready = reset when flush = 1.
//   At each clock edge, in priority order:
//     1. flush: ex_valid <= 0. if_instr is consumed and dropped.
//     2. !advance: the whole ID/EX register holds its value.
//     3. hazard or !if_valid: bubble. ex_valid <= 0; the other ex_* fields are don't-care.
//     4. Otherwise: capture the decoded fields and set ex_valid <= 1.
//   Operand value:
//     - If rs == 0, the operand is 0.
//     - Else if wb_wEn & wb_write_sel == rs, the operand is wb_write_data.
//     - Else the operand is read_data.
//   Immediate by opcode:
//     - I-type: LOAD 0000011, OP-IMM 0010011, JALR 1100111.
//     - S-type: STORE 0100011.
//     - B-type: BRANCH 1100011.
//     - U-type: LUI 0110111, AUIPC 0010111.
//     - J-type: JAL 1101111.
//     - OP 0110011: imm = 0.
//   B-type and J-type immediates have bit 0 = 0. All immediates sign-extend from instr[31].
//   ex_reg_write is 1 for every legal opcode except STORE and BRANCH.
//   Illegal opcode: ex_illegal = 1, ex_reg_write = 0, ex_mem_read = 0.
//   Latency: an accepted instruction appears on ex_* one cycle later.
//   A load-use pair costs exactly one bubble.
//   Reset asserted mid-stall clears the stall. The held fetch instruction is re-presented after reset.
// TESTING
//   1. ADDI x1,x0,5 (0x00500093) with if_valid = 1 and ex_ready = 1
//      -> next cycle: ex_valid = 1, ex_imm = 5, ex_rd = 1, ex_reg_write = 1, ex_rs1_val = 0.
//   2. ADD x3,x1,x2 with read_data1 = 7 and wb_wEn = 1, wb_write_sel = 1, wb_write_data = 9
//      -> ex_rs1_val = 9. Repeat with wb_write_sel = 0 -> ex_rs1_val = 7.
//   3. LW x5,0(x1), then ADD x6,x5,x5
//      -> during the ADD cycle: id_ready = 0. Next edge: ex_valid = 0 (bubble).
//      -> the cycle after: the ADD is captured.
//   4. ex_ready = 0 for 3 cycles with ex_valid = 1
//      -> ex_* stable and id_ready = 0. When ex_ready = 1, the next instruction is latched.
//   5. flush = 1 together with ex_ready = 0 and if_valid = 1
//      -> id_ready = 1 and ex_valid = 0 next cycle.
//   6. BEQ with imm = -8 (0xFE000CE3) -> ex_imm = 0xFFFFFFF8, ex_reg_write = 0.
//      Opcode 0x7F -> ex_illegal = 1.
//      reset = 0 mid-stream -> all ex_* = 0.

Source files
------------

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage: operand bypass, immediates, load-use stall, ID/EX register
module decode_stage #(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            if_valid,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   output logic            id_ready,
   output logic [4:0]      read_sel1,
   output logic [4:0]      read_sel2,
   input  logic [XLEN-1:0] read_data1,
   input  logic [XLEN-1:0] read_data2,
   input  logic            wb_wEn,
   input  logic [4:0]      wb_write_sel,
   input  logic [XLEN-1:0] wb_write_data,
   input  logic            ex_ready,
   input  logic            flush,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_val,
   output logic [XLEN-1:0] ex_rs2_val,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rd,
   output logic [6:0]      ex_opcode,
   output logic [2:0]      ex_funct3,
   output logic            ex_funct7b5,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_illegal
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   logic [6:0]      opcode;
   logic [4:0]      rs1, rs2;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [XLEN-1:0] d_imm;
   logic [4:0]      d_rd;
   logic            d_legal, d_rs1_used, d_rs2_used, d_reg_write, d_mem_read;
   logic            advance, hazard;

   assign opcode    = if_instr[6:0];
   assign rs1       = if_instr[19:15];
   assign rs2       = if_instr[24:20];
   assign read_sel1 = rs1;
   assign read_sel2 = rs2;

   assign imm_i = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
   assign imm_s = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
   assign imm_b = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                   if_instr[11:8], 1'b0};
   assign imm_u = {{(XLEN-31){if_instr[31]}}, if_instr[30:12], 12'b0};
   assign imm_j = {{(XLEN-21){if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                   if_instr[30:21], 1'b0};

   always_comb begin
      d_imm       = '0;
      d_legal     = 1'b1;
      d_rs1_used  = 1'b1;
      d_rs2_used  = 1'b0;
      d_reg_write = 1'b1;
      d_mem_read  = 1'b0;
      case (opcode)
         OP_LOAD: begin
            d_imm      = imm_i;
            d_mem_read = 1'b1;
         end
         OP_IMM, OP_JALR: d_imm = imm_i;
         OP_STORE: begin
            d_imm       = imm_s;
            d_rs2_used  = 1'b1;
            d_reg_write = 1'b0;
         end
         OP_BRANCH: begin
            d_imm       = imm_b;
            d_rs2_used  = 1'b1;
            d_reg_write = 1'b0;
         end
         OP_OP: d_rs2_used = 1'b1;
         OP_LUI, OP_AUIPC: begin
            d_imm      = imm_u;
            d_rs1_used = 1'b0;
         end
         OP_JAL: begin
            d_imm      = imm_j;
            d_rs1_used = 1'b0;
         end
         default: begin
            d_legal     = 1'b0;
            d_reg_write = 1'b0;
         end
      endcase
      d_rd = d_reg_write ? if_instr[11:7] : 5'd0;
   end

   // The writeback value lands in the regfile at this same edge, so forward it.
   function automatic logic [XLEN-1:0] operand(input logic [4:0] sel, input logic [XLEN-1:0] rf);
      if (sel == 5'd0)
         return '0;
      else if (wb_wEn && wb_write_sel == sel)
         return wb_write_data;
      else
         return rf;
   endfunction

   assign advance  = !ex_valid || ex_ready;
   assign hazard   = ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                     ((d_rs1_used && rs1 == ex_rd) || (d_rs2_used && rs2 == ex_rd));
   assign id_ready = reset && (flush || (advance && !hazard));

   always_ff @(posedge clock) begin
      if (!reset) begin
         ex_valid     <= 1'b0;
         ex_pc        <= '0;
         ex_rs1_val   <= '0;
         ex_rs2_val   <= '0;
         ex_imm       <= '0;
         ex_rd        <= '0;
         ex_opcode    <= '0;
         ex_funct3    <= '0;
         ex_funct7b5  <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_illegal   <= 1'b0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (advance) begin
         if (hazard || !if_valid) begin
            ex_valid <= 1'b0;
         end else begin
            ex_valid     <= 1'b1;
            ex_pc        <= if_pc;
            ex_rs1_val   <= operand(rs1, read_data1);
            ex_rs2_val   <= operand(rs2, read_data2);
            ex_imm       <= d_imm;
            ex_rd        <= d_rd;
            ex_opcode    <= opcode;
            ex_funct3    <= if_instr[14:12];
            ex_funct7b5  <= if_instr[30];
            ex_reg_write <= d_reg_write;
            ex_mem_read  <= d_mem_read;
            ex_illegal   <= !d_legal;
         end
      end
   end

endmodule
